fifo_rd_rr_arbiter: RTL

//  Drains N_PORTS async-FIFO read sides (r_clk domain) into one registered

---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/fifo_rd_rr_arbiter_rr_pick.sv | 28 ++
 rtl/fifo_rd_rr_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO read-side round-robin arbiter:
// state encoding and the ceil(log2) helper used to size index/counter fields.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_rd_rr_arbiter_rr_pick.sv
// Rotating priority encoder: returns the first set request found when
// searching base, base+1, ... (mod N). Purely combinational.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int SRC_W = clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SRC_W-1:0] base,
    output logic [SRC_W-1:0] idx,
    output logic             any
);

    logic [SRC_W-1:0] cand_s;

    // Scan offsets from farthest to nearest so the nearest requester wins last
    always_comb begin
        idx    = {SRC_W{1'b0}};
        cand_s = {SRC_W{1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            cand_s = SRC_W'((int'(base) + k) % N);
            idx    = req[cand_s] ? cand_s : idx;
        end
        any = |req;
    end

endmodule

// File: rtl/fifo_rd_rr_arbiter.sv
// Drains N_PORTS first-word-fall-through FIFO read sides into one registered
// valid/ready stream. Ports are served round-robin with bursts of up to
// MAX_BURST pops per grant; one IDLE arbitration cycle separates grants.
module fifo_rd_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int N_PORTS    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int SRC_W      = clog2(N_PORTS),
    localparam int CNT_W      = clog2(MAX_BURST) + 1
) (
    input  logic                          r_clk,
    input  logic                          r_rst,
    input  logic [N_PORTS-1:0]            en_mask,
    input  logic [N_PORTS-1:0]            r_empty,
    input  logic [N_PORTS*DATA_WIDTH-1:0] r_data_bus,
    output logic [N_PORTS-1:0]            r_inc,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]              out_src,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam logic [N_PORTS-1:0] ONE_HOT0 = N_PORTS'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [SRC_W-1:0]   SRC_LAST = SRC_W'(N_PORTS - 1);

    arb_state_e            state_r;
    logic [SRC_W-1:0]      rr_ptr_r;
    logic [SRC_W-1:0]      grant_r;
    logic [CNT_W-1:0]      burst_cnt_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [SRC_W-1:0]      out_src_r;
    logic                  out_valid_r;

    logic [N_PORTS-1:0]    elig_s;
    logic                  grant_elig_s;
    logic                  out_free_s;
    logic                  pop_s;
    logic                  release_s;
    logic [SRC_W-1:0]      next_ptr_s;
    logic [SRC_W-1:0]      pick_idx_s;
    logic                  pick_any_s;
    logic [DATA_WIDTH-1:0] grant_data_s;

    assign elig_s       = en_mask & ~r_empty;
    assign grant_elig_s = elig_s[grant_r];
    assign out_free_s   = ~out_valid_r | out_ready;
    // Pop is suppressed combinationally while reset is asserted
    assign pop_s        = ~r_rst & (state_r == ST_BURST) & grant_elig_s & out_free_s;
    // Burst ends on the last allowed pop, or as soon as the granted port
    // is no longer eligible (empty or masked), whether or not it popped
    assign release_s    = (pop_s & (burst_cnt_r == CNT_LAST)) | ~grant_elig_s;
    assign next_ptr_s   = (grant_r == SRC_LAST) ? {SRC_W{1'b0}} : (grant_r + SRC_W'(1));
    assign grant_data_s = r_data_bus[int'(grant_r) * DATA_WIDTH +: DATA_WIDTH];

    assign r_inc     = pop_s ? (ONE_HOT0 << grant_r) : {N_PORTS{1'b0}};
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;
    assign out_valid = out_valid_r;
    assign busy      = (state_r == ST_BURST);

    rr_pick #(
        .N     (N_PORTS),
        .SRC_W (SRC_W)
    ) u_rr_pick (
        .req  (elig_s),
        .base (rr_ptr_r),
        .idx  (pick_idx_s),
        .any  (pick_any_s)
    );

    // Grant/burst state machine: arbitrate in IDLE, count pops in BURST
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= {SRC_W{1'b0}};
            grant_r     <= {SRC_W{1'b0}};
            burst_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        grant_r     <= pick_idx_s;
                        burst_cnt_r <= {CNT_W{1'b0}};
                        state_r     <= ST_BURST;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (release_s) begin
                        state_r     <= ST_IDLE;
                        rr_ptr_r    <= next_ptr_s;
                        burst_cnt_r <= {CNT_W{1'b0}};
                    end else if (pop_s) begin
                        burst_cnt_r <= burst_cnt_r + CNT_W'(1);
                    end else begin
                        burst_cnt_r <= burst_cnt_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register: load on pop, drop valid once accepted without a refill
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_src_r   <= {SRC_W{1'b0}};
        end else if (pop_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= grant_data_s;
            out_src_r   <= grant_r;
        end else if (out_ready & out_valid_r) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule
